// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, aligner state and token classifier.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned CAT_W = 2 * SYM_W;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] bits;
  } ctrl_info_t;

  // Classify a symbol; bits are forced to 0 when it is not a control token.
  function automatic ctrl_info_t is_ctrl_token(input logic [SYM_W-1:0] word);
    ctrl_info_t info;
    info = '0;
    case (word)
      CTRL_TOKEN_00: info = '{valid: 1'b1, bits: 2'b00};
      CTRL_TOKEN_01: info = '{valid: 1'b1, bits: 2'b01};
      CTRL_TOKEN_10: info = '{valid: 1'b1, bits: 2'b10};
      CTRL_TOKEN_11: info = '{valid: 1'b1, bits: 2'b11};
      default:       info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/tmds_word_aligner_window.sv
// Datapath: previous-word register and 20->10 barrel selector by bit offset.
module tmds_bit_window
  import tmds_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] raw_data,
  input  logic [OFF_W-1:0] offset,
  output logic [SYM_W-1:0] win_c
);

  logic [SYM_W-1:0] prev;
  logic [CAT_W-1:0] cat;

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= raw_data;
  end

  assign cat = {raw_data, prev};

  // Offsets above 9 never occur; they fall back to offset 0.
  always_comb begin
    win_c = cat[SYM_W-1:0];
    for (int k = 0; k < SYM_W; k++) begin
      if (offset == OFF_W'(k)) win_c = cat[k +: SYM_W];
    end
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: hunts for runs of control tokens across the ten bit
// offsets, locks on the boundary and emits aligned symbols with decoded ctrl.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN_MIN   = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1024,
  parameter int unsigned LOSS_TIMEOUT   = 8192
) (
  input  logic             paralell_clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] raw_data,
  input  logic             force_resync,
  output logic [SYM_W-1:0] aligned_data,
  output logic             aligned_valid,
  output logic             ctrl_valid,
  output logic [1:0]       ctrl_bits,
  output logic [OFF_W-1:0] bit_offset,
  output logic             locked
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN_MIN) + 1;
  localparam int unsigned TMO_W  = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

  align_state_t     state;
  logic [RUN_W-1:0] run_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic [SYM_W-1:0] win;
  logic [OFF_W-1:0] offset_next;
  ctrl_info_t       tok;

  tmds_bit_window u_window (
    .clk      (paralell_clk),
    .reset    (reset),
    .raw_data (raw_data),
    .offset   (bit_offset),
    .win_c    (win)
  );

  always_comb begin
    tok         = is_ctrl_token(win);
    offset_next = (bit_offset == OFF_W'(9)) ? '0 : bit_offset + OFF_W'(1);
  end

  // State, counters and registered outputs.
  always_ff @(posedge paralell_clk) begin
    if (reset) begin
      state         <= SEARCH;
      run_cnt       <= '0;
      tmo_cnt       <= '0;
      loss_cnt      <= '0;
      bit_offset    <= '0;
      locked        <= 1'b0;
      aligned_valid <= 1'b0;
      aligned_data  <= '0;
      ctrl_valid    <= 1'b0;
      ctrl_bits     <= '0;
    end else begin
      aligned_data <= win;
      ctrl_valid   <= tok.valid;
      ctrl_bits    <= tok.bits;

      if (force_resync) begin
        state         <= SEARCH;
        bit_offset    <= offset_next;
        run_cnt       <= '0;
        tmo_cnt       <= '0;
        loss_cnt      <= '0;
        locked        <= 1'b0;
        aligned_valid <= 1'b0;
      end else if (state == SEARCH) begin
        if (tok.valid && run_cnt == RUN_W'(CTRL_RUN_MIN - 1)) begin
          state         <= LOCKED;
          run_cnt       <= '0;
          tmo_cnt       <= '0;
          loss_cnt      <= '0;
          locked        <= 1'b1;
          aligned_valid <= 1'b1;
        end else if (tmo_cnt == TMO_W'(SEARCH_TIMEOUT - 1)) begin
          bit_offset <= offset_next;
          run_cnt    <= '0;
          tmo_cnt    <= '0;
        end else begin
          if (!tok.valid)        run_cnt <= '0;
          else if (run_cnt != '1) run_cnt <= run_cnt + RUN_W'(1);
          if (tmo_cnt != '1)     tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        if (tok.valid) begin
          loss_cnt <= '0;
        end else if (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1)) begin
          state         <= SEARCH;
          run_cnt       <= '0;
          tmo_cnt       <= '0;
          loss_cnt      <= '0;
          locked        <= 1'b0;
          aligned_valid <= 1'b0;
        end else if (loss_cnt != '1) begin
          loss_cnt <= loss_cnt + LOSS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner with a short search timeout.
module tb_tmds_word_aligner;
  import tmds_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] raw_data = '0;
  logic       force_resync = 1'b0;
  logic [9:0] aligned_data;
  logic       aligned_valid;
  logic       ctrl_valid;
  logic [1:0] ctrl_bits;
  logic [3:0] bit_offset;
  logic       locked;

  int tests = 0;
  int fails = 0;

  localparam logic [9:0] FILL = 10'h1F0;

  tmds_word_aligner #(
    .CTRL_RUN_MIN   (8),
    .SEARCH_TIMEOUT (16),
    .LOSS_TIMEOUT   (8192)
  ) dut (
    .paralell_clk  (clk),
    .reset         (reset),
    .raw_data      (raw_data),
    .force_resync  (force_resync),
    .aligned_data  (aligned_data),
    .aligned_valid (aligned_valid),
    .ctrl_valid    (ctrl_valid),
    .ctrl_bits     (ctrl_bits),
    .bit_offset    (bit_offset),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Token carried by serial word m: mode 0 = 20x T00 then T11, mode 1 = all T00.
  function automatic logic [9:0] tok_of(input int mode, input int m);
    if (mode == 0 && m >= 20) return CTRL_TOKEN_11;
    return CTRL_TOKEN_00;
  endfunction

  // Deserializer word n when the serial stream arrives d bits late (bit 0 first).
  function automatic logic [9:0] word_at(input int mode, input int n, input int d);
    logic [9:0] w;
    logic [9:0] t;
    int k;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      k = 10 * n + i - d;
      if (k >= 0) begin
        t = tok_of(mode, k / 10);
        w[i] = t[k % 10];
      end
    end
    return w;
  endfunction

  task automatic step(input logic [9:0] w);
    raw_data = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(10'($urandom));
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (aligned_data !== 10'h000) begin fails++; $display("FAIL reset_aligned_data got=%h exp=000", aligned_data); end
    tests++; if (aligned_valid !== 1'b0) begin fails++; $display("FAIL reset_aligned_valid got=%b exp=0", aligned_valid); end
    tests++; if (ctrl_valid !== 1'b0) begin fails++; $display("FAIL reset_ctrl_valid got=%b exp=0", ctrl_valid); end
    tests++; if (ctrl_bits !== 2'b00) begin fails++; $display("FAIL reset_ctrl_bits got=%b exp=00", ctrl_bits); end
    tests++; if (bit_offset !== 4'd0) begin fails++; $display("FAIL reset_bit_offset got=%0d exp=0", bit_offset); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b exp=0", locked); end
  endtask

  task automatic test_aligned();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(word_at(0, c, 0));
      if (c == 5) begin
        tests++; if (aligned_data !== CTRL_TOKEN_00) begin fails++; $display("FAIL aligned_data_t00 got=%h exp=%h", aligned_data, CTRL_TOKEN_00); end
        tests++; if (ctrl_valid !== 1'b1) begin fails++; $display("FAIL aligned_ctrl_valid got=%b exp=1", ctrl_valid); end
      end
      if (c == 7) begin
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL aligned_early_lock got=%b exp=0", locked); end
      end
      if (c == 8) begin
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL aligned_lock got=%b exp=1", locked); end
        tests++; if (aligned_valid !== 1'b1) begin fails++; $display("FAIL aligned_valid got=%b exp=1", aligned_valid); end
      end
      if (c == 20) begin
        tests++; if (ctrl_bits !== 2'b00) begin fails++; $display("FAIL aligned_bits_00 got=%b exp=00", ctrl_bits); end
      end
      if (c == 21) begin
        tests++; if (ctrl_bits !== 2'b11) begin fails++; $display("FAIL aligned_bits_11 got=%b exp=11", ctrl_bits); end
        tests++; if (aligned_data !== CTRL_TOKEN_11) begin fails++; $display("FAIL aligned_data_t11 got=%h exp=%h", aligned_data, CTRL_TOKEN_11); end
      end
    end
  endtask

  task automatic test_tokens();
    logic [9:0] seq [5];
    logic [2:0] exp [5];
    seq[0] = CTRL_TOKEN_01; exp[0] = 3'b101;
    seq[1] = CTRL_TOKEN_10; exp[1] = 3'b110;
    seq[2] = CTRL_TOKEN_00; exp[2] = 3'b100;
    seq[3] = CTRL_TOKEN_11; exp[3] = 3'b111;
    seq[4] = FILL;          exp[4] = 3'b000;
    do_reset();
    step(seq[0]);
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? seq[i + 1] : FILL);
      tests++;
      if ({ctrl_valid, ctrl_bits} !== exp[i] || aligned_data !== seq[i]) begin
        fails++;
        $display("FAIL token_decode_%0d got=%b/%b/%h exp=%b/%b/%h", i, ctrl_valid, ctrl_bits,
                 aligned_data, exp[i][2], exp[i][1:0], seq[i]);
      end
    end
  endtask

  task automatic test_rotated();
    do_reset();
    for (int c = 0; c < 130; c++) begin
      step(word_at(1, c, 7));
      if (c == 14) begin tests++; if (bit_offset !== 4'd0) begin fails++; $display("FAIL rot_off_c14 got=%0d exp=0", bit_offset); end end
      if (c == 15) begin tests++; if (bit_offset !== 4'd1) begin fails++; $display("FAIL rot_off_c15 got=%0d exp=1", bit_offset); end end
      if (c == 110) begin tests++; if (bit_offset !== 4'd6) begin fails++; $display("FAIL rot_off_c110 got=%0d exp=6", bit_offset); end end
      if (c == 111) begin tests++; if (bit_offset !== 4'd7) begin fails++; $display("FAIL rot_off_c111 got=%0d exp=7", bit_offset); end end
      if (c == 118) begin tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rot_early_lock got=%b exp=0", locked); end end
      if (c == 119) begin tests++; if (locked !== 1'b1) begin fails++; $display("FAIL rot_lock got=%b exp=1", locked); end end
      if (c == 125) begin
        tests++;
        if (bit_offset !== 4'd7 || aligned_data !== CTRL_TOKEN_00 || ctrl_valid !== 1'b1) begin
          fails++;
          $display("FAIL rot_locked_data got=%0d/%h/%b exp=7/%h/1", bit_offset, aligned_data, ctrl_valid, CTRL_TOKEN_00);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 175; c++) begin
      step((c < 160) ? FILL : CTRL_TOKEN_00);
      if (c == 143) begin tests++; if (bit_offset !== 4'd9) begin fails++; $display("FAIL wrap_off9 got=%0d exp=9", bit_offset); end end
      if (c == 159) begin tests++; if (bit_offset !== 4'd0) begin fails++; $display("FAIL wrap_off0 got=%0d exp=0", bit_offset); end end
      if (c == 167) begin tests++; if (locked !== 1'b0) begin fails++; $display("FAIL wrap_early_lock got=%b exp=0", locked); end end
      if (c == 168) begin
        tests++;
        if (locked !== 1'b1 || bit_offset !== 4'd0) begin
          fails++;
          $display("FAIL wrap_lock got=%b/%0d exp=1/0", locked, bit_offset);
        end
      end
    end
  endtask

  task automatic test_loss(input bit restart);
    int drop_c;
    drop_c = restart ? 16212 : 8212;
    do_reset();
    for (int c = 0; c <= drop_c + 2; c++) begin
      step((c < 20 || (restart && c == 8019)) ? CTRL_TOKEN_00 : FILL);
      if (c == 8) begin tests++; if (locked !== 1'b1) begin fails++; $display("FAIL loss_initial_lock got=%b exp=1", locked); end end
      if (restart && c == 8212) begin
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL loss_restart_hold got=%b exp=1", locked); end
      end
      if (c == drop_c - 1) begin
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL loss_before_drop r=%0d got=%b exp=1", restart, locked); end
      end
      if (c == drop_c) begin
        tests++;
        if (locked !== 1'b0 || aligned_valid !== 1'b0 || bit_offset !== 4'd0) begin
          fails++;
          $display("FAIL loss_drop r=%0d got=%b/%b/%0d exp=0/0/0", restart, locked, aligned_valid, bit_offset);
        end
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      force_resync = (c == 8);
      step(word_at(1, c, 0));
      force_resync = 1'b0;
      if (c == 8) begin
        tests++;
        if (locked !== 1'b0 || aligned_valid !== 1'b0 || bit_offset !== 4'd1) begin
          fails++;
          $display("FAIL collision got=%b/%b/%0d exp=0/0/1", locked, aligned_valid, bit_offset);
        end
      end
      if (c == 11) begin
        tests++;
        if (locked !== 1'b0 || bit_offset !== 4'd1) begin
          fails++;
          $display("FAIL collision_after got=%b/%0d exp=0/1", locked, bit_offset);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int n = 0; n < 181; n++) begin
      reset = (n == 91);
      step(word_at(1, n, 5));
      reset = 1'b0;
      if (n == 87) begin tests++; if (locked !== 1'b1) begin fails++; $display("FAIL midrst_lock got=%b exp=1", locked); end end
      if (n == 90) begin tests++; if (bit_offset !== 4'd5) begin fails++; $display("FAIL midrst_off5 got=%0d exp=5", bit_offset); end end
      if (n == 91) begin
        tests++;
        if (locked !== 1'b0 || bit_offset !== 4'd0 || aligned_data !== 10'h000) begin
          fails++;
          $display("FAIL midrst_reset got=%b/%0d/%h exp=0/0/000", locked, bit_offset, aligned_data);
        end
      end
      if (n == 178) begin tests++; if (locked !== 1'b0) begin fails++; $display("FAIL midrst_early_relock got=%b exp=0", locked); end end
      if (n == 179) begin
        tests++;
        if (locked !== 1'b1 || bit_offset !== 4'd5) begin
          fails++;
          $display("FAIL midrst_relock got=%b/%0d exp=1/5", locked, bit_offset);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_tokens();
    test_rotated();
    test_wrap();
    test_loss(1'b0);
    test_loss(1'b1);
    test_collision();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
